// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor memory subsystem.
// Holds the RAM arbiter state encoding and requester tags.
package k_and_s_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_CPU      = 2'd1,
        ARB_DBG      = 2'd2,
        ARB_DBG_LOCK = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } arb_port_t;

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous RAM port between the CPU datapath
// and a debug/loader port with round-robin fairness and a bounded lock.
// Ports: clk, rst_n (async, active-low);
//   cpu_* / dbg_* : req, we, addr, wdata in; gnt, rvalid, rdata out;
//   dbg_lock      : keep debug ownership while dbg_req stays high;
//   ram_*         : addr, we, wdata to RAM; rdata from RAM (1-cycle latency).
module ram_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic                  dbg_lock,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [7:0] LP_LOCK_MAX = 8'(LOCK_MAX);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [7:0]      r_lock_cnt;
    logic [7:0]      w_lock_cnt_nxt;
    logic            r_pend;
    arb_port_t       r_tag;
    logic [DATA_WIDTH-1:0] r_cpu_hold;
    logic [DATA_WIDTH-1:0] r_dbg_hold;

    logic            w_cpu_win;
    logic            w_dbg_win;
    logic            w_cpu_rv;
    logic            w_dbg_rv;

    // Arbitration decision from current requests and previous owner.
    always_comb begin
        w_cpu_win = 1'b0;
        w_dbg_win = 1'b0;
        if (cpu_req && dbg_req) begin
            case (r_state)
                ARB_CPU: w_dbg_win = 1'b1;
                ARB_DBG_LOCK: begin
                    if (r_lock_cnt < LP_LOCK_MAX) w_dbg_win = 1'b1;
                    else                          w_cpu_win = 1'b1;
                end
                default: w_cpu_win = 1'b1;
            endcase
        end else begin
            w_cpu_win = cpu_req;
            w_dbg_win = dbg_req;
        end
    end

    // Grants are forced low while reset is held, even with requests high.
    assign cpu_gnt = w_cpu_win & rst_n;
    assign dbg_gnt = w_dbg_win & rst_n;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            ram_addr  = dbg_addr;
            ram_we    = dbg_we;
            ram_wdata = dbg_wdata;
        end
    end

    // Lock counter: the entry grant counts as the first locked grant.
    always_comb begin
        w_state_nxt    = ARB_IDLE;
        w_lock_cnt_nxt = 8'd0;
        if (cpu_gnt) begin
            w_state_nxt = ARB_CPU;
        end else if (dbg_gnt) begin
            if (dbg_lock) begin
                w_state_nxt = ARB_DBG_LOCK;
                if (r_state != ARB_DBG_LOCK)
                    w_lock_cnt_nxt = 8'd1;
                else if (r_lock_cnt == 8'hFF)
                    w_lock_cnt_nxt = r_lock_cnt;
                else
                    w_lock_cnt_nxt = r_lock_cnt + 8'd1;
            end else begin
                w_state_nxt = ARB_DBG;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_lock_cnt <= 8'd0;
            r_pend     <= 1'b0;
            r_tag      <= PORT_CPU;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_pend     <= (cpu_gnt | dbg_gnt) & ~ram_we;
            r_tag      <= dbg_gnt ? PORT_DBG : PORT_CPU;
        end
    end

    assign w_cpu_rv   = r_pend && (r_tag == PORT_CPU);
    assign w_dbg_rv   = r_pend && (r_tag == PORT_DBG);
    assign cpu_rvalid = w_cpu_rv;
    assign dbg_rvalid = w_dbg_rv;

    // Returned data passes straight through on its rvalid cycle and is
    // captured so the port keeps showing it until its next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_hold <= '0;
            r_dbg_hold <= '0;
        end else begin
            if (w_cpu_rv) r_cpu_hold <= ram_rdata;
            if (w_dbg_rv) r_dbg_hold <= ram_rdata;
        end
    end

    assign cpu_rdata = w_cpu_rv ? ram_rdata : r_cpu_hold;
    assign dbg_rdata = w_dbg_rv ? ram_rdata : r_dbg_hold;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single synchronous RAM port of the K&S processor between two requesters: the CPU datapath (instruction fetch, LOAD, STORE, as sequenced by the control unit) and a debug/loader port used to preload programs and inspect memory. It provides a per-cycle request/grant handshake, round-robin fairness, a bounded debug lock for burst loading, and routes read data back to the requester that issued the read. It sits between the datapath address/data buses and the RAM macro.

## Interface
- ADDR_WIDTH, 5, RAM word-address width
- DATA_WIDTH, 16, RAM word width
- LOCK_MAX, 8, max consecutive locked debug grants before the CPU gets a slot; range 1..255
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  CPU access issued to RAM this cycle
- cpu_rvalid  out  1  cpu_rdata valid, one cycle after a granted read
- cpu_rdata  out  DATA_WIDTH  read data to CPU
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same directions, widths and meanings as the CPU set
- dbg_lock  in  1  request that the debug port keep ownership while dbg_req stays high
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after a read is issued

## Operation
- Grant is combinational from the current requests and registered arbitration state; at most one of cpu_gnt/dbg_gnt is high in any cycle; a grant is never given without a request.
- Granted port's addr/we/wdata are muxed onto the RAM port in the same cycle; with no grant, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Arbitration state (registered owner of the previous cycle): ARB_IDLE, ARB_CPU, ARB_DBG, ARB_DBG_LOCK.
- Single requester: granted immediately.
- Both requesting, state ARB_IDLE or ARB_DBG: CPU wins. State ARB_CPU: debug wins. Strict alternation under continuous contention.
- Lock: a debug grant with dbg_lock = 1 enters/stays in ARB_DBG_LOCK and increments lock_cnt (8-bit, cleared on entry, saturating). In ARB_DBG_LOCK, debug wins ties while lock_cnt < LOCK_MAX; once lock_cnt = LOCK_MAX and cpu_req = 1, the CPU gets the next slot and state becomes ARB_CPU. Dropping dbg_req or dbg_lock leaves the lock (next state from the actual grant).
- Next state: ARB_CPU if cpu_gnt, ARB_DBG/ARB_DBG_LOCK if dbg_gnt (per dbg_lock), else ARB_IDLE.
- Read return: a granted read (we = 0) sets a registered pending flag and owner tag; next cycle the matching rvalid pulses for one cycle and ram_rdata is presented on that port's rdata (registered pass-through; the other port's rdata holds its last value). Writes produce no rvalid.
- Back-to-back reads from alternating ports each return correctly tagged data on consecutive cycles.

## Timing
- Reset (async assert, sync release on clk): state ARB_IDLE, lock_cnt 0, pending 0; cpu_gnt/dbg_gnt/ram_we 0, cpu_rvalid/dbg_rvalid 0, cpu_rdata/dbg_rdata 0, ram_addr/ram_wdata 0.
- Grant latency: 0 cycles from req when uncontended; worst case 1 cycle for the CPU outside lock, LOCK_MAX cycles inside lock.
- Read latency: rvalid exactly 1 cycle after gnt of a read; throughput one access per cycle.
- Reset mid-read: pending read discarded, no rvalid after release.
- Requester drops req without gnt: legal, no side effect.

## Structure
- arb_state_t enum (ARB_IDLE, ARB_CPU, ARB_DBG, ARB_DBG_LOCK) and arb_port_t (PORT_CPU, PORT_DBG) go in k_and_s_pkg.
- Single module; no sub-module: the round-robin decision is a few lines of combinational logic.

## Test plan
- Reset with both reqs high: all outputs 0 during reset; first cycle after release cpu_gnt = 1, dbg_gnt = 0.
- CPU write 0xBEEF to addr 3, then CPU read addr 3: ram_we = 1 on first grant; cpu_rvalid = 1 with cpu_rdata = 0xBEEF one cycle after the read grant, dbg_rvalid stays 0.
- Both reqs held 6 cycles, no lock: grants alternate CPU, DBG, CPU, DBG, CPU, DBG.
- dbg_lock = 1, LOCK_MAX = 8, both reqs held: 8 consecutive dbg_gnt, then one cpu_gnt, then locked debug grants resume.
- Alternating reads: CPU reads addr 1 (0x0011), DBG reads addr 2 (0x0022) on consecutive cycles: cpu_rvalid with 0x0011 then dbg_rvalid with 0x0022 on the following cycle.
- rst_n asserted the cycle after a granted read: no rvalid after release, state ARB_IDLE.
